// File: rtl/dfd_list_drain_ctrl_if.sv
// dfd_list_drain_ctrl_if: call handshake plus req/ack/eol/value list port of a dfd_* function.
interface dfd_list_drain_ctrl_if #(parameter int DATA_W = 8);
    logic              f_ready;
    logic              f_done;
    logic [DATA_W-1:0] f_arg0;
    logic [DATA_W-1:0] f_arg1;
    logic              req;
    logic              ack;
    logic              eol;
    logic [DATA_W-1:0] value;
    modport master(output f_ready, f_arg0, f_arg1, req, input f_done, ack, eol, value);
    modport slave(input f_ready, f_arg0, f_arg1, req, output f_done, ack, eol, value);
endinterface

// File: rtl/dfd_list_drain_ctrl.sv
// dfd_list_drain_ctrl: calls a list-producing function once and drains its list into count/sum/min/max.
module dfd_list_drain_ctrl #(
    parameter int DATA_W  = 8,
    parameter int SUM_W   = 16,
    parameter int MAX_LEN = 64,
    parameter int TIMEOUT = 1024,
    localparam int CW = $clog2(MAX_LEN + 1),
    localparam int TW = $clog2(TIMEOUT + 1)
) (
    input  logic                      CLOCK_50,
    input  logic                      RESET_N,
    input  logic                      start,
    input  logic [DATA_W-1:0]         arg0,
    input  logic [DATA_W-1:0]         arg1,
    dfd_list_drain_ctrl_if.master     lp,
    output logic                      busy,
    output logic                      result_valid,
    output logic [CW-1:0]             count,
    output logic [SUM_W-1:0]          sum,
    output logic [DATA_W-1:0]         min_v,
    output logic [DATA_W-1:0]         max_v,
    output logic [1:0]                err
);
    typedef enum logic [2:0] {IDLE, CALL, REQ, GAP, DONE, ERR} state_t;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
    localparam logic [CW-1:0] CMAX = CW'(MAX_LEN);
    state_t            state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [CW-1:0]     count_q, count_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic [DATA_W-1:0] min_q, min_d, max_q, max_d, a0_q, a0_d, a1_q, a1_d;
    logic [1:0]        err_q, err_d;
    logic              tmo;
    assign tmo = timer_q == TMAX;
    always_comb begin
        state_d = state_q;
        timer_d = tmo ? timer_q : timer_q + 1'b1;
        count_d = count_q;
        sum_d   = sum_q;
        min_d   = min_q;
        max_d   = max_q;
        a0_d    = a0_q;
        a1_d    = a1_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (start) begin
                    state_d = CALL;
                    a0_d    = arg0;
                    a1_d    = arg1;
                    count_d = '0;
                    sum_d   = '0;
                    min_d   = '0;
                    max_d   = '0;
                    err_d   = 2'b00;
                end
            end
            CALL: begin
                if (lp.f_done) begin
                    state_d = REQ;
                    timer_d = '0;
                end else if (tmo) begin
                    state_d = ERR;
                    err_d   = 2'b01;
                end
            end
            REQ: begin
                if (lp.ack) begin
                    if (lp.eol) state_d = DONE;
                    else if (count_q == CMAX) begin
                        state_d = ERR;
                        err_d   = 2'b10;
                    end else begin
                        state_d = GAP;
                        count_d = count_q + 1'b1;
                        sum_d   = sum_q + {{(SUM_W-DATA_W){lp.value[DATA_W-1]}}, lp.value};
                        // first element seeds both extremes
                        min_d   = (count_q == '0 || $signed(lp.value) < $signed(min_q)) ? lp.value : min_q;
                        max_d   = (count_q == '0 || $signed(lp.value) > $signed(max_q)) ? lp.value : max_q;
                    end
                end else if (tmo) begin
                    state_d = ERR;
                    err_d   = 2'b01;
                end
            end
            GAP: begin
                if (!lp.ack) begin
                    state_d = REQ;
                    timer_d = '0;
                end else if (tmo) begin
                    state_d = ERR;
                    err_d   = 2'b01;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            timer_q <= '0;
            count_q <= '0;
            sum_q   <= '0;
            min_q   <= '0;
            max_q   <= '0;
            a0_q    <= '0;
            a1_q    <= '0;
            err_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            count_q <= count_d;
            sum_q   <= sum_d;
            min_q   <= min_d;
            max_q   <= max_d;
            a0_q    <= a0_d;
            a1_q    <= a1_d;
            err_q   <= err_d;
        end
    end
    assign lp.f_ready    = state_q == CALL || state_q == REQ || state_q == GAP;
    assign lp.req        = state_q == REQ;
    assign lp.f_arg0     = a0_q;
    assign lp.f_arg1     = a1_q;
    assign busy          = state_q != IDLE;
    assign result_valid  = state_q == DONE;
    assign count         = count_q;
    assign sum           = sum_q;
    assign min_v         = min_q;
    assign max_v         = max_q;
    assign err           = err_q;
endmodule

// File: tb/tb_dfd_list_drain_ctrl.sv
// tb_dfd_list_drain_ctrl: directed steps with hand-computed expectations, DUT built with MAX_LEN=4, TIMEOUT=16.
module tb_dfd_list_drain_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] arg0 = '0, arg1 = '0;
    logic       busy, result_valid;
    logic [2:0] count;
    logic [15:0] sum;
    logic [7:0] min_v, max_v;
    logic [1:0] err;
    int total = 0, bad = 0;

    dfd_list_drain_ctrl_if #(.DATA_W(8)) lp();

    dfd_list_drain_ctrl #(.DATA_W(8), .SUM_W(16), .MAX_LEN(4), .TIMEOUT(16)) dut (
        .CLOCK_50(clk), .RESET_N(rst_n), .start(start), .arg0(arg0), .arg1(arg1), .lp(lp),
        .busy(busy), .result_valid(result_valid), .count(count), .sum(sum),
        .min_v(min_v), .max_v(max_v), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic call(input logic [7:0] a0, input logic [7:0] a1);
        arg0 = a0;
        arg1 = a1;
        start = 1'b1;
        tick();
        start = 1'b0;
        lp.f_done = 1'b1;
        tick();
        lp.f_done = 1'b0;
    endtask

    // waits for req, answers after dly cycles and holds ack for hold cycles
    task automatic serve(input string tag, input logic [7:0] v, input logic e, input int dly, input int hold);
        int n = 0;
        while (lp.req !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_req"}, lp.req, 1);
        repeat (dly) tick();
        lp.ack = 1'b1;
        lp.eol = e;
        lp.value = v;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, "_reqlow"}, lp.req, 0);
        end
        lp.ack = 1'b0;
        lp.eol = 1'b0;
        lp.value = '0;
    endtask

    initial begin
        int n;
        lp.f_done = 1'b0;
        lp.ack = 1'b0;
        lp.eol = 1'b0;
        lp.value = '0;
        #12;
        chk("rst_f_ready", lp.f_ready, 0);
        chk("rst_req", lp.req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rv", result_valid, 0);
        chk("rst_acc", {count, sum, min_v}, 0);
        chk("rst_misc", {max_v, err, lp.f_arg0, lp.f_arg1}, 0);
        rst_n = 1'b1;
        tick();

        // list [5,-7,2]
        arg0 = 8'hFE;
        arg1 = 8'h03;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t1_f_ready", lp.f_ready, 1);
        chk("t1_busy", busy, 1);
        chk("t1_arg0", lp.f_arg0, 8'hFE);
        chk("t1_arg1", lp.f_arg1, 8'h03);
        tick();
        lp.f_done = 1'b1;
        tick();
        lp.f_done = 1'b0;
        serve("t1_e0", 8'd5, 1'b0, 2, 1);
        serve("t1_e1", 8'hF9, 1'b0, 2, 1);
        serve("t1_e2", 8'd2, 1'b0, 2, 1);
        serve("t1_eol", 8'h00, 1'b1, 2, 1);
        chk("t1_rv", result_valid, 1);
        chk("t1_count", count, 3);
        chk("t1_sum", sum, 0);
        chk("t1_min", min_v, 8'hF9);
        chk("t1_max", max_v, 8'h05);
        chk("t1_err", err, 0);
        chk("t1_f_ready_done", lp.f_ready, 0);
        tick();
        chk("t1_rv_once", result_valid, 0);
        chk("t1_idle", busy, 0);

        // empty list
        call(8'h01, 8'h02);
        serve("t2_eol", 8'h33, 1'b1, 0, 1);
        chk("t2_rv", result_valid, 1);
        chk("t2_acc", {count, sum, min_v, max_v}, 0);
        tick();
        chk("t2_rv_once", result_valid, 0);

        // f_done never comes
        arg0 = 8'h00;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (err === 2'b00 && n < 40) begin
            tick();
            n++;
        end
        chk("t3_cycles", n, 17);
        chk("t3_err", err, 1);
        chk("t3_f_ready", lp.f_ready, 0);
        tick();
        chk("t3_busy", busy, 0);
        chk("t3_err_hold", err, 1);

        // overflow at MAX_LEN=4
        call(8'h00, 8'h00);
        serve("t4_e0", 8'd10, 1'b0, 0, 1);
        serve("t4_e1", 8'd20, 1'b0, 0, 1);
        serve("t4_e2", 8'd30, 1'b0, 0, 1);
        serve("t4_e3", 8'd40, 1'b0, 0, 1);
        serve("t4_e4", 8'd50, 1'b0, 0, 1);
        chk("t4_err", err, 2);
        chk("t4_count", count, 4);
        chk("t4_sum", sum, 100);
        chk("t4_rv", result_valid, 0);
        tick();
        chk("t4_rv_after", result_valid, 0);
        chk("t4_idle", busy, 0);

        // ack held three cycles per element
        call(8'h00, 8'h00);
        chk("t5_err_clear", err, 0);
        serve("t5_e0", 8'd1, 1'b0, 1, 3);
        serve("t5_e1", 8'hFF, 1'b0, 1, 3);
        serve("t5_e2", 8'd100, 1'b0, 1, 3);
        serve("t5_eol", 8'h00, 1'b1, 1, 3);
        chk("t5_count", count, 3);
        chk("t5_sum", sum, 100);
        chk("t5_min", min_v, 8'hFF);
        chk("t5_max", max_v, 8'd100);
        tick();
        chk("t5_idle", busy, 0);

        // async reset while req is high, then a fresh call
        call(8'h11, 8'h22);
        chk("t6_req_pre", lp.req, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_req", lp.req, 0);
        chk("t6_f_ready", lp.f_ready, 0);
        chk("t6_busy", busy, 0);
        chk("t6_arg", {lp.f_arg0, lp.f_arg1}, 0);
        tick();
        rst_n = 1'b1;
        tick();
        call(8'h07, 8'hF8);
        chk("t6_arg0", lp.f_arg0, 8'h07);
        chk("t6_arg1", lp.f_arg1, 8'hF8);
        serve("t6_e0", 8'hFD, 1'b0, 0, 1);
        serve("t6_eol", 8'h00, 1'b1, 0, 1);
        chk("t6_rv", result_valid, 1);
        chk("t6_count", count, 1);
        chk("t6_sum", sum, 16'hFFFD);
        chk("t6_minmax", {min_v, max_v}, 16'hFDFD);
        chk("t6_err", err, 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dfd_list_drain_ctrl.md
Name: dfd_list_drain_ctrl

Overview:
Sequences one call of a list-producing dataflow function (dfd_* style: ready/done call handshake, req/ack/eol/value list port). It latches two signed arguments on start, holds ready, and waits for done. It then pulls list elements one at a time, accumulating count, sum, min and max. Results are presented with a one-cycle valid strobe, with timeout and overflow error reporting. It replaces the hand-written free-running request generators on the board top level.

Parameters:
DATA_W, 8, width of arguments and list elements (two's complement)
SUM_W, 16, width of sum accumulator (wraps modulo 2^SUM_W)
MAX_LEN, 64, max elements accepted before overflow error
TIMEOUT, 1024, cycles allowed waiting for done or ack before timeout error

Ports:
CLOCK_50  in  1  system clock, all logic on rising edge
RESET_N  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; accepted only in IDLE
arg0  in  DATA_W  first function argument, signed
arg1  in  DATA_W  second function argument, signed
f_ready  out  1  call request to function; held high from CALL entry until DONE/ERR
f_done  in  1  function has completed setup; list port valid
f_arg0  out  DATA_W  latched arg0
f_arg1  out  DATA_W  latched arg1
req  out  1  element request to list port
ack  in  1  list port response strobe
eol  in  1  end of list, qualified by ack
value  in  DATA_W  list element, qualified by ack and not eol
busy  out  1  high in every state except IDLE
result_valid  out  1  one-cycle strobe in DONE
count  out  clog2(MAX_LEN+1)  elements received
sum  out  SUM_W  sign-extended sum of elements
min_v  out  DATA_W  smallest element (signed); 0 if list empty
max_v  out  DATA_W  largest element (signed); 0 if list empty
err  out  2  00 none, 01 timeout, 10 overflow; sticky until next start

Behaviour:
- Reset (async, RESET_N low): state IDLE. All outputs 0: f_ready, req, busy, result_valid, count, sum, min_v, max_v, err, f_arg0, f_arg1.
- IDLE: on start, latch arg0/arg1 into f_arg0/f_arg1 and clear count, sum, min_v, max_v, err and the timer. Go to CALL. f_ready goes high in the cycle after the start pulse.
- CALL: f_ready=1. On f_done=1, go to REQ. If the timer reaches TIMEOUT first, go to ERR with err=01.
- REQ: req=1, held until ack is sampled high. The timer is reset on REQ entry.
  - On ack with eol=0: record value. count+1, sum += sign-extended value. min_v/max_v update (first element initialises both). Go to GAP.
  - On ack with eol=1: go to DONE; value is ignored.
  - If count is already MAX_LEN and ack arrives with eol=0: go to ERR with err=10; the element is not accumulated.
  - If the timer reaches TIMEOUT: go to ERR with err=01.
- GAP: req=0. Wait for ack=0, then return to REQ. Minimum req-low time is one cycle (four-phase handshake). Timeout applies here too.
- DONE: result_valid=1 for exactly one cycle, then IDLE. f_ready drops on entry to DONE. count/sum/min_v/max_v hold until the next start.
- ERR: f_ready=0, req=0, result_valid=0. Stay one cycle, then IDLE; err holds.
- start outside IDLE is ignored.
- Timer width is clog2(TIMEOUT+1) and saturates; it never wraps.
- sum wraps silently. count never exceeds MAX_LEN.
- ack while req=0 in REQ-entry cycles cannot occur legally. If ack is still high on GAP exit, REQ is not entered until ack falls.
- Reset mid-operation aborts immediately. Outputs return to reset values the same cycle (async).
- Latency: start→f_ready 1 cycle. Ack→req low 1 cycle. eol-ack→result_valid 1 cycle.

Test Plan:
- Args -2, 3. Function returns list [5,-7,2] then eol, ack 2 cycles after each req → result_valid once; count=3, sum=0, min_v=-7, max_v=5, err=00, f_arg0=0xFE, f_arg1=0x03.
- Empty list: f_done, then the first ack has eol=1 → count=0, sum=0, min_v=0, max_v=0, result_valid one cycle after ack.
- f_done never asserted, TIMEOUT=16 → err=01 in 17 cycles after CALL entry, f_ready low, busy low the following cycle.
- MAX_LEN=4, producer sends 5 elements without eol → err=10, count=4, sum of the first 4 only, no result_valid.
- ack held high for 3 cycles per element → req stays low in GAP until ack falls; no double-counting; count matches element count.
- RESET_N pulsed low in REQ with req=1 → req, f_ready and busy go 0 immediately. A start after reset runs a fresh call with cleared accumulators.
